// File: rtl/delay_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : delay_sequencer_if
//  Description : Signal bundle between the game controller / 2 kHz timing
//                counter (master side) and the delay sequencer (slave side).
//                The master drives the request, the abort and the counter
//                flags. The slave drives the counter controls and the status
//                and pulse outputs.
//  Signals     : i_Req, i_Steps, i_Abort   game-controller request side
//                i_TwoSec, i_RstOK         timing-counter flags
//                o_ActCounter, o_RstCounter counter controls
//                o_Busy, o_Tick, o_Done, o_Aborted, o_StepCnt  status
//  Revision    : 1.0 - initial release
// ============================================================================
interface delay_sequencer_if #(
    parameter int STEP_W = 4
);
    logic              i_Req;
    logic [STEP_W-1:0] i_Steps;
    logic              i_Abort;
    logic              i_TwoSec;
    logic              i_RstOK;
    logic              o_ActCounter;
    logic              o_RstCounter;
    logic              o_Busy;
    logic              o_Tick;
    logic              o_Done;
    logic              o_Aborted;
    logic [STEP_W-1:0] o_StepCnt;

    modport master (
        output i_Req, i_Steps, i_Abort, i_TwoSec, i_RstOK,
        input  o_ActCounter, o_RstCounter, o_Busy, o_Tick, o_Done,
               o_Aborted, o_StepCnt
    );

    modport slave (
        input  i_Req, i_Steps, i_Abort, i_TwoSec, i_RstOK,
        output o_ActCounter, o_RstCounter, o_Busy, o_Tick, o_Done,
               o_Aborted, o_StepCnt
    );
endinterface
`default_nettype wire

// File: rtl/delay_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : delay_sequencer
//  Description : Drives the 2 kHz timing counter on behalf of the game FSM.
//                A one-cycle request carrying N chains N back-to-back ~2 s
//                intervals: each interval clears the counter, then runs it
//                until the two-second flag. A tick pulses per completed
//                interval and a done pulse marks the end of the sequence.
//                An abort cancels a running sequence.
//  Ports       : clk_2K      2 kHz system clock
//                i_ResetNeg  asynchronous reset, active high
//                bus         delay_sequencer_if.slave (request, abort,
//                            counter flags in; counter controls, busy,
//                            tick/done/aborted pulses, step count out)
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_sequencer #(
    parameter int STEP_W = 4
) (
    input  wire logic         clk_2K,
    input  wire logic         i_ResetNeg,
    delay_sequencer_if.slave  bus
);

    localparam logic [2:0] c_StIdle  = 3'd0;
    localparam logic [2:0] c_StClear = 3'd1;
    localparam logic [2:0] c_StRun   = 3'd2;
    localparam logic [2:0] c_StDone  = 3'd3;
    localparam logic [2:0] c_StAbort = 3'd4;

    logic [2:0]        r_State;
    logic [2:0]        w_NextState;
    logic [STEP_W-1:0] r_Remaining;
    logic [STEP_W-1:0] r_StepCnt;
    logic              r_Tick;
    logic              w_IntervalDone;

    logic w_ActCounter;
    logic w_RstCounter;
    logic w_Busy;
    logic w_Done;
    logic w_Aborted;

    // An interval only counts when it is not overridden by an abort in the
    // same cycle.
    assign w_IntervalDone = (r_State == c_StRun) && bus.i_TwoSec && !bus.i_Abort;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2K or posedge i_ResetNeg) begin
        if (i_ResetNeg) begin
            r_State <= c_StIdle;
        end else begin
            r_State <= w_NextState;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_NextState = r_State;
        case (r_State)
            c_StIdle: begin
                if (bus.i_Req) begin
                    w_NextState = (bus.i_Steps == '0) ? c_StDone : c_StClear;
                end
            end
            c_StClear: begin
                if (bus.i_Abort) begin
                    w_NextState = c_StAbort;
                end else if (bus.i_RstOK) begin
                    w_NextState = c_StRun;
                end
            end
            c_StRun: begin
                if (bus.i_Abort) begin
                    w_NextState = c_StAbort;
                end else if (bus.i_TwoSec) begin
                    // The counter saturates with i_TwoSec held high, so every
                    // further interval must pass through CLEAR again.
                    w_NextState = (r_Remaining == STEP_W'(1)) ? c_StDone : c_StClear;
                end
            end
            c_StDone: begin
                w_NextState = bus.i_Abort ? c_StAbort : c_StIdle;
            end
            c_StAbort: begin
                // The counter is left with a clear request for one cycle only;
                // the next sequence clears it again before running.
                w_NextState = c_StIdle;
            end
            default: begin
                w_NextState = c_StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Interval bookkeeping and registered tick
    // ------------------------------------------------------------------
    always_ff @(posedge clk_2K or posedge i_ResetNeg) begin
        if (i_ResetNeg) begin
            r_Remaining <= '0;
            r_StepCnt   <= '0;
            r_Tick      <= 1'b0;
        end else begin
            r_Tick <= w_IntervalDone;
            if ((r_State == c_StIdle) && bus.i_Req) begin
                r_Remaining <= bus.i_Steps;
                r_StepCnt   <= '0;
            end else if (w_IntervalDone) begin
                r_Remaining <= r_Remaining - STEP_W'(1);
                r_StepCnt   <= r_StepCnt + STEP_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode (state register only, no input-to-output path)
    // ------------------------------------------------------------------
    always_comb begin
        w_ActCounter = 1'b0;
        w_RstCounter = 1'b0;
        w_Busy       = 1'b0;
        w_Done       = 1'b0;
        w_Aborted    = 1'b0;
        case (r_State)
            c_StClear: begin
                w_RstCounter = 1'b1;
                w_Busy       = 1'b1;
            end
            c_StRun: begin
                w_ActCounter = 1'b1;
                w_Busy       = 1'b1;
            end
            c_StDone: begin
                w_Done = 1'b1;
                w_Busy = 1'b1;
            end
            c_StAbort: begin
                w_RstCounter = 1'b1;
                w_Aborted    = 1'b1;
                w_Busy       = 1'b1;
            end
            default: begin
                w_Busy = 1'b0;
            end
        endcase
    end

    assign bus.o_ActCounter = w_ActCounter;
    assign bus.o_RstCounter = w_RstCounter;
    assign bus.o_Busy       = w_Busy;
    assign bus.o_Done       = w_Done;
    assign bus.o_Aborted    = w_Aborted;
    assign bus.o_Tick       = r_Tick;
    assign bus.o_StepCnt    = r_StepCnt;

endmodule
`default_nettype wire

// File: tb/tb_delay_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_sequencer
//  Description : Bench for delay_sequencer. Includes a 4-bit timing-counter
//                model (16 run cycles per interval) with programmable clear
//                acknowledge latency. A timeline model derived from the
//                interval rules predicts pulses and level outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_sequencer;

    localparam int STEP_W = 4;
    localparam int CW     = 4;
    localparam int CMAX   = (1 << CW) - 1;
    localparam int RUNLEN = 1 << CW;
    localparam int TMAX   = 512;

    typedef struct {
        int cyc;
        bit tick;
        bit done;
        bit ab;
        int cnt;
    } ev_t;

    logic clk_2K = 1'b0;
    logic rst    = 1'b1;
    int   cyc    = 0;
    int   nTests = 0;
    int   nFail  = 0;

    ev_t expQ[$];

    // counter model state
    logic [CW-1:0] cnt = '0;
    int clrRun = 0;
    int accCnt = 0;
    int accBase = 0;
    int stalls[16];
    int stIdx;

    // expected level timeline, indexed by relative cycle
    bit eAct[TMAX];
    bit eRst[TMAX];
    bit eBusy[TMAX];

    always #5 clk_2K = ~clk_2K;

    delay_sequencer_if #(.STEP_W(STEP_W)) bus();

    delay_sequencer #(.STEP_W(STEP_W)) dut (
        .clk_2K    (clk_2K),
        .i_ResetNeg(rst),
        .bus       (bus)
    );

    // Timing counter model: cleared on edges while the clear request is up,
    // counts while enabled, saturates at all-ones. The clear acknowledge is
    // withheld for stalls[k] cycles during the k-th clear of a sequence.
    always @(posedge clk_2K) begin
        cyc <= cyc + 1;
        if (bus.o_RstCounter) begin
            cnt    <= '0;
            clrRun <= clrRun + 1;
            if (bus.i_RstOK) accCnt <= accCnt + 1;
        end else begin
            clrRun <= 0;
            if (bus.o_ActCounter && cnt != CW'(CMAX)) cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        stIdx = accCnt - accBase;
        if (stIdx < 0 || stIdx > 15) stIdx = 0;
    end

    assign bus.i_TwoSec = (cnt == CW'(CMAX));
    assign bus.i_RstOK  = bus.o_RstCounter && (clrRun >= stalls[stIdx]);

    // Scoreboard monitor: every pulse cycle pops one expected event.
    task automatic monitor();
        ev_t e;
        forever begin
            @(posedge clk_2K);
            #1;
            if (!rst && (bus.o_Tick || bus.o_Done || bus.o_Aborted)) begin
                nTests++;
                if (expQ.size() == 0) begin
                    nFail++;
                    $display("FAIL unexpected_pulse cyc=%0d tick=%b done=%b ab=%b cnt=%0d",
                             cyc, bus.o_Tick, bus.o_Done, bus.o_Aborted, bus.o_StepCnt);
                end else begin
                    e = expQ.pop_front();
                    if (e.cyc != cyc || e.tick != bus.o_Tick || e.done != bus.o_Done ||
                        e.ab != bus.o_Aborted || e.cnt != int'(bus.o_StepCnt)) begin
                        nFail++;
                        $display("FAIL pulse got cyc=%0d tick=%b done=%b ab=%b cnt=%0d exp cyc=%0d tick=%b done=%b ab=%b cnt=%0d",
                                 cyc, bus.o_Tick, bus.o_Done, bus.o_Aborted, bus.o_StepCnt,
                                 e.cyc, e.tick, e.done, e.ab, e.cnt);
                    end
                end
            end
        end
    endtask

    // One sequence: build the expected timeline from the interval rules,
    // queue the expected pulses, then drive and check levels each cycle.
    // abortAt / xr1 / xr2 are relative cycles (0 = unused).
    task automatic runTxn(input int n, input int abortAt, input int xr1, input int xr2,
                          input string tag);
        ev_t q[$];
        ev_t e;
        int  t, tc, s, last, finalCnt, base, kept;
        for (int c = 0; c < TMAX; c++) begin
            eAct[c] = 0; eRst[c] = 0; eBusy[c] = 0;
        end
        t = 1;
        if (n == 0) begin
            eBusy[1] = 1;
            q.push_back('{1, 1'b0, 1'b1, 1'b0, 0});
        end else begin
            for (int k = 0; k < n; k++) begin
                s = stalls[k];
                for (int c = t; c <= t + s; c++) begin eRst[c] = 1; eBusy[c] = 1; end
                for (int c = t + s + 1; c <= t + s + RUNLEN; c++) begin eAct[c] = 1; eBusy[c] = 1; end
                tc = t + s + RUNLEN + 1;
                eBusy[tc] = 1;
                q.push_back('{tc, 1'b1, (k == n - 1), 1'b0, k + 1});
                t = tc;
            end
        end
        last     = t;
        finalCnt = n;
        if (abortAt > 0) begin
            for (int c = abortAt + 1; c < TMAX; c++) begin
                eAct[c] = 0; eRst[c] = 0; eBusy[c] = 0;
            end
            eRst[abortAt + 1]  = 1;
            eBusy[abortAt + 1] = 1;
            kept = 0;
            for (int i = 0; i < q.size(); i++) if (q[i].cyc <= abortAt) kept++;
            while (q.size() > kept) void'(q.pop_back());
            q.push_back('{abortAt + 1, 1'b0, 1'b0, 1'b1, kept});
            finalCnt = kept;
            last     = abortAt + 1;
        end

        base    = cyc;
        accBase = accCnt;
        foreach (q[i]) begin
            e = q[i];
            e.cyc = e.cyc + base;
            expQ.push_back(e);
        end
        bus.i_Req   = 1'b1;
        bus.i_Steps = STEP_W'(n);
        bus.i_Abort = 1'b0;
        for (int r = 1; r <= last + 1; r++) begin
            @(negedge clk_2K);
            bus.i_Req = (r == xr1) || (r == xr2);
            if (bus.i_Req) bus.i_Steps = STEP_W'($urandom_range(1, 15));
            bus.i_Abort = (r == abortAt);
            nTests++;
            if ({bus.o_ActCounter, bus.o_RstCounter, bus.o_Busy} !== {eAct[r], eRst[r], eBusy[r]}) begin
                nFail++;
                $display("FAIL %s levels r=%0d act/rst/busy got %b%b%b exp %b%b%b", tag, r,
                         bus.o_ActCounter, bus.o_RstCounter, bus.o_Busy, eAct[r], eRst[r], eBusy[r]);
            end
        end
        bus.i_Req   = 1'b0;
        bus.i_Abort = 1'b0;
        for (int w = 0; w < 4 && expQ.size() != 0; w++) @(negedge clk_2K);
        nTests++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL %s missing_pulses got %0d pending exp 0", tag, expQ.size());
            expQ.delete();
        end
        nTests++;
        if (int'(bus.o_StepCnt) != finalCnt) begin
            nFail++;
            $display("FAIL %s stepcnt got %0d exp %0d", tag, bus.o_StepCnt, finalCnt);
        end
    endtask

    task automatic chkIdleZero(input string tag, input logic [STEP_W-1:0] expCnt);
        nTests++;
        if ({bus.o_ActCounter, bus.o_RstCounter, bus.o_Busy, bus.o_Tick, bus.o_Done,
             bus.o_Aborted, bus.o_StepCnt} !== {6'b0, expCnt}) begin
            nFail++;
            $display("FAIL %s outputs got act=%b rst=%b busy=%b tick=%b done=%b ab=%b cnt=%0d exp all 0 cnt=%0d",
                     tag, bus.o_ActCounter, bus.o_RstCounter, bus.o_Busy, bus.o_Tick,
                     bus.o_Done, bus.o_Aborted, bus.o_StepCnt, expCnt);
        end
    endtask

    initial begin
        int n, s, dc, ab, xr;
        foreach (stalls[i]) stalls[i] = 0;
        bus.i_Req   = 1'b0;
        bus.i_Steps = '0;
        bus.i_Abort = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk_2K);
        chkIdleZero("reset_state", '0);
        rst = 1'b0;
        @(negedge clk_2K);

        runTxn(1, 0, 0, 0, "steps1");
        runTxn(3, 0, 0, 0, "steps3");
        runTxn(0, 0, 0, 0, "steps0");
        runTxn(2, 10, 0, 0, "abort_run");
        runTxn(2, 17, 0, 0, "abort_twosec");
        runTxn(1, 0, 5, 18, "req_ignored");
        stalls[0] = 10;
        runTxn(1, 0, 0, 0, "clear_stall");
        stalls[0] = 0;

        // abort while idle must be ignored
        bus.i_Abort = 1'b1;
        repeat (2) @(negedge clk_2K);
        bus.i_Abort = 1'b0;
        @(negedge clk_2K);
        chkIdleZero("abort_idle", STEP_W'(1));

        // asynchronous reset mid-RUN
        bus.i_Req   = 1'b1;
        bus.i_Steps = STEP_W'(2);
        @(negedge clk_2K);
        bus.i_Req = 1'b0;
        repeat (7) @(negedge clk_2K);
        #2;
        rst = 1'b1;
        #1;
        chkIdleZero("reset_mid_run", '0);
        repeat (3) @(negedge clk_2K);
        chkIdleZero("reset_held", '0);
        rst = 1'b0;
        @(negedge clk_2K);
        runTxn(1, 0, 0, 0, "after_reset");

        // randomized sequences
        for (int it = 0; it < 14; it++) begin
            n  = $urandom_range(0, 4);
            dc = 0;
            for (int k = 0; k < 16; k++) stalls[k] = 0;
            for (int k = 0; k < n; k++) begin
                s = $urandom_range(0, 3);
                stalls[k] = s;
                dc = dc + s + RUNLEN + 1;
            end
            ab = 0;
            xr = 0;
            if (n > 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, dc - 1);
            else if (n > 0) xr = $urandom_range(2, dc);
            runTxn(n, ab, xr, 0, "random");
            repeat ($urandom_range(0, 3)) @(negedge clk_2K);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/delay_sequencer.md
Name: delay_sequencer

Overview:
- Controller-side driver of the 2 kHz timing counter. It issues the counter's activate and clear requests and consumes its two-second-elapsed and clear-acknowledge flags.
- The game controller hands it a one-cycle request carrying N intervals. The block chains N back-to-back ~2 s waits, pulses a tick per completed interval and a done pulse at the end.
- Sits between the BlackJack game FSM and the counter. Replaces ad-hoc counter handling inside the game FSM.

Parameters:
STEP_W, 4, width of the interval-count request and the completed-interval counter (max 2^STEP_W-1 intervals).

Ports:
clk_2K  input  1  2 kHz system clock
i_ResetNeg  input  1  reset, asynchronous, active-high
i_Req  input  1  one-cycle start request from game FSM; sampled only in IDLE
i_Steps  input  STEP_W  number of 2 s intervals; latched with i_Req
i_Abort  input  1  cancel the running sequence; honoured in any non-IDLE state
i_TwoSec  input  1  counter flag: current interval elapsed
i_RstOK  input  1  counter flag: clear request accepted
o_ActCounter  output  1  counter enable
o_RstCounter  output  1  counter synchronous clear request
o_Busy  output  1  high in every state except IDLE
o_Tick  output  1  one-cycle pulse per completed interval
o_Done  output  1  one-cycle pulse when all intervals have completed
o_Aborted  output  1  one-cycle pulse when a sequence is cancelled
o_StepCnt  output  STEP_W  intervals completed in the current or last sequence

Behaviour:
- Reset: asynchronous on i_ResetNeg high. State goes to IDLE and every output is 0. r_Remaining=0, o_StepCnt=0. Reset mid-sequence drops o_ActCounter and o_Busy immediately, with no Done or Aborted pulse.
- States: IDLE, CLEAR, RUN, DONE, ABORT. All outputs decode from registered state/flops, with no combinational path from inputs to outputs.
- IDLE:
  - Outputs 0 except o_StepCnt, which holds its last value.
  - i_Req=1 latches i_Steps into r_Remaining and clears o_StepCnt.
  - If i_Steps==0, go to DONE. Otherwise go to CLEAR.
- CLEAR:
  - o_RstCounter=1, o_ActCounter=0.
  - When i_RstOK=1, go to RUN. Otherwise stay; there is no timeout.
  - i_TwoSec is ignored.
- RUN:
  - o_ActCounter=1, o_RstCounter=0.
  - On i_TwoSec=1: o_StepCnt+1, r_Remaining-1, and o_Tick=1 in the next cycle.
  - Next state is DONE if r_Remaining==1, else CLEAR.
  - The CLEAR re-entry is mandatory: the counter saturates at all-ones and keeps i_TwoSec high.
- DONE:
  - o_Done=1 for exactly one cycle, o_ActCounter=0.
  - Then IDLE.
- ABORT:
  - o_RstCounter=1 and o_Aborted=1 for one cycle, o_ActCounter=0.
  - Then IDLE unconditionally, without waiting for i_RstOK.
  - o_StepCnt keeps the partial count.
- Priority in any state: i_ResetNeg > i_Abort > i_TwoSec/i_RstOK.
  - i_Abort in the same cycle as i_TwoSec goes to ABORT, with no tick and no StepCnt increment.
  - i_Abort in IDLE is ignored.
- i_Req outside IDLE is ignored, including the DONE cycle. Requests are not queued.
- Timing:
  - Req accepted at edge E0: CLEAR in cycle 1.
  - The counter is zeroed at E1. RUN runs from cycle 2 for 2^CW cycles (CW = counter width).
  - Each interval is therefore 2^CW+1 cycles (4097 cycles, ~2.05 s, for CW=12).
- Arithmetic: r_Remaining and o_StepCnt are unsigned STEP_W. o_StepCnt cannot wrap because it is bounded by i_Steps.

Test Plan (bench counter model CW=4, so each interval = 17 cycles; i_Req pulsed before edge E0, cycle n follows edge En-1):
- Reset: assert i_ResetNeg mid-RUN with Steps=2 -> o_ActCounter, o_Busy and all pulses are 0 immediately; o_StepCnt=0; after release, next i_Req starts normally.
- Steps=1 -> o_RstCounter high cycle 1; o_ActCounter high cycles 2-17; i_TwoSec at cycle 17; o_Tick and o_Done high cycle 18; o_StepCnt=1; o_Busy low from cycle 19.
- Steps=3 -> o_Tick at cycles 18, 35, 52; o_RstCounter at cycles 1, 18, 35; o_Done at cycle 52 only; o_StepCnt=3.
- Steps=0 -> o_Done high cycle 1; o_ActCounter and o_RstCounter never asserted; o_StepCnt=0.
- Steps=2 with i_Abort at cycle 10 -> ABORT in cycle 11 (o_RstCounter=1, o_Aborted=1); IDLE in cycle 12; no o_Done; o_StepCnt=0.
  - Repeat with i_Abort coincident with i_TwoSec at cycle 17 -> o_Aborted high in cycle 18, no o_Tick, o_StepCnt=0.
- i_Req pulsed at cycles 5 and 18 during Steps=1 -> both ignored; single o_Done at cycle 18.
  - Hold i_RstOK low in CLEAR for 10 cycles -> block stays in CLEAR with o_RstCounter=1, then proceeds to RUN on the cycle after i_RstOK rises.
